// File: rtl/pci_cfg_target.sv
// pci_cfg_target -- PCI Type 0 configuration-cycle target sequencer.
//
// Claims Type 0 config reads/writes with fast DEVSEL timing and one data
// phase per transaction (bursts are disconnected with STOP#). Each claimed
// transaction issues exactly one request to the downstream config-space
// register block and, for reads, returns its data on AD with PAR.
//
// Ports:
//   clk, rst              PCI clock (rising edge); async active-low reset
//   frame_n, irdy_n       initiator control
//   idsel, ad_in, cbe_n   sampled IDSEL / AD / C/BE#
//   par_in                sampled PAR (parity check build only)
//   ad_out/ad_oe          AD drive value / enable
//   trdy_n, devsel_n,
//   stop_n, ctl_oe        target control values / shared enable
//   par_out/par_oe        PAR drive value / enable
//   cfg_*                 register request (one-cycle cfg_enable strobe)
//   cfg_read_val          read data from the register block
//   detected_parity_error one-cycle parity error pulse
//
// Parameter TURNAROUND_CYCLES (1..3): idle cycles after a transaction
// before a new address phase is decoded.
//
// Optional macro PCI_CFG_TARGET_PARITY_CHECK_EN: enables checking of
// address/write-data parity against par_in; otherwise
// detected_parity_error is tied 0.

module pci_cfg_target #(
  parameter int TURNAROUND_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_n,
  input  logic        irdy_n,
  input  logic        idsel,
  input  logic [31:0] ad_in,
  input  logic [3:0]  cbe_n,
  input  logic        par_in,
  output logic [31:0] ad_out,
  output logic        ad_oe,
  output logic        trdy_n,
  output logic        devsel_n,
  output logic        stop_n,
  output logic        ctl_oe,
  output logic        par_out,
  output logic        par_oe,
  output logic        cfg_enable,
  output logic        cfg_iswrite,
  output logic [5:0]  cfg_offset,
  output logic [31:0] cfg_write_val,
  output logic [3:0]  cfg_byte_en,
  input  logic [31:0] cfg_read_val,
  output logic        detected_parity_error
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, WR_DATA, TURN} state_t;

  localparam logic [1:0] TURN_LAST = 2'(TURNAROUND_CYCLES - 1);

  state_t      state_q, state_d;
  logic [1:0]  turn_cnt_q, turn_cnt_d;
  logic        frame_prev_q;
  logic        hit;

  logic [31:0] ad_out_d, write_val_d;
  logic        ad_oe_d, trdy_d, devsel_d, stop_d, ctl_oe_d;
  logic        par_out_d, par_oe_d, cfg_en_d, iswrite_d;
  logic [5:0]  offset_d;
  logic [3:0]  byte_en_d;

  // Address phase = falling edge of FRAME#. Only function 0, Type 0,
  // config read (1010) / write (1011) is claimed.
  assign hit = !frame_n && frame_prev_q && idsel && (ad_in[1:0] == 2'b00) &&
               (ad_in[10:8] == 3'b000) && (cbe_n[3:1] == 3'b101);

  always_comb begin
    state_d     = state_q;
    turn_cnt_d  = turn_cnt_q;
    ad_out_d    = ad_out;
    ad_oe_d     = ad_oe;
    trdy_d      = trdy_n;
    devsel_d    = devsel_n;
    stop_d      = stop_n;
    ctl_oe_d    = ctl_oe;
    par_out_d   = par_out;
    par_oe_d    = par_oe;
    cfg_en_d    = 1'b0;
    iswrite_d   = cfg_iswrite;
    offset_d    = cfg_offset;
    write_val_d = cfg_write_val;
    byte_en_d   = cfg_byte_en;

    // Bus release outside a transaction: first drive control lines high
    // for a cycle, then tri-state them (and PAR).
    if (state_q == IDLE || state_q == TURN) begin
      if (!devsel_n) begin
        trdy_d   = 1'b1;
        devsel_d = 1'b1;
        stop_d   = 1'b1;
      end else begin
        ctl_oe_d = 1'b0;
        par_oe_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: if (hit) begin
        offset_d = ad_in[7:2];
        devsel_d = 1'b0;
        ctl_oe_d = 1'b1;
        if (cbe_n[0]) begin
          trdy_d  = 1'b0;
          state_d = WR_DATA;
        end else begin
          cfg_en_d  = 1'b1;
          iswrite_d = 1'b0;
          state_d   = RD_REQ;
        end
      end
      RD_REQ: begin
        ad_out_d = cfg_read_val;
        ad_oe_d  = 1'b1;
        trdy_d   = 1'b0;
        stop_d   = frame_n;   // FRAME# still low -> burst, disconnect with data
        state_d  = RD_DATA;
      end
      RD_DATA: if (!irdy_n && !trdy_n) begin
        par_out_d  = ^{ad_out, cbe_n};
        par_oe_d   = 1'b1;
        ad_oe_d    = 1'b0;
        trdy_d     = 1'b1;
        devsel_d   = 1'b1;
        stop_d     = 1'b1;
        turn_cnt_d = 2'd0;
        state_d    = TURN;
      end
      WR_DATA: if (!irdy_n) begin
        cfg_en_d    = 1'b1;
        iswrite_d   = 1'b1;
        write_val_d = ad_in;
        byte_en_d   = ~cbe_n;
        // TRDY# drops so a burst's second word is never accepted; STOP#
        // alone then tells the initiator to end the burst.
        trdy_d      = 1'b1;
        stop_d      = frame_n;
        turn_cnt_d  = 2'd0;
        state_d     = TURN;
      end
      TURN: begin
        if (turn_cnt_q == TURN_LAST) state_d = IDLE;
        else                         turn_cnt_d = turn_cnt_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      turn_cnt_q    <= 2'd0;
      frame_prev_q  <= 1'b1;
      ad_out        <= 32'd0;
      ad_oe         <= 1'b0;
      trdy_n        <= 1'b1;
      devsel_n      <= 1'b1;
      stop_n        <= 1'b1;
      ctl_oe        <= 1'b0;
      par_out       <= 1'b0;
      par_oe        <= 1'b0;
      cfg_enable    <= 1'b0;
      cfg_iswrite   <= 1'b0;
      cfg_offset    <= 6'd0;
      cfg_write_val <= 32'd0;
      cfg_byte_en   <= 4'd0;
    end else begin
      state_q       <= state_d;
      turn_cnt_q    <= turn_cnt_d;
      frame_prev_q  <= frame_n;
      ad_out        <= ad_out_d;
      ad_oe         <= ad_oe_d;
      trdy_n        <= trdy_d;
      devsel_n      <= devsel_d;
      stop_n        <= stop_d;
      ctl_oe        <= ctl_oe_d;
      par_out       <= par_out_d;
      par_oe        <= par_oe_d;
      cfg_enable    <= cfg_en_d;
      cfg_iswrite   <= iswrite_d;
      cfg_offset    <= offset_d;
      cfg_write_val <= write_val_d;
      cfg_byte_en   <= byte_en_d;
    end
  end

`ifdef PCI_CFG_TARGET_PARITY_CHECK_EN
  // PAR lags its AD/CBE# phase by one clock: remember the expected even
  // parity, compare on the following edge.
  logic par_exp_q, par_chk_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_exp_q             <= 1'b0;
      par_chk_q             <= 1'b0;
      detected_parity_error <= 1'b0;
    end else begin
      par_chk_q             <= 1'b0;
      detected_parity_error <= par_chk_q && (par_in != par_exp_q);
      if ((state_q == IDLE && hit) || (state_q == WR_DATA && !irdy_n)) begin
        par_chk_q <= 1'b1;
        par_exp_q <= ^{ad_in, cbe_n};
      end
    end
  end
`else
  // Checking disabled: output constant 0 (par_in is referenced only here).
  assign detected_parity_error = par_in & 1'b0;
`endif

endmodule

// File: tb/tb_pci_cfg_target.sv
module tb_pci_cfg_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_n, irdy_n, idsel, par_in;
  logic [31:0] ad_in;
  logic [3:0]  cbe_n;
  logic [31:0] ad_out, cfg_write_val, cfg_read_val;
  logic        ad_oe, trdy_n, devsel_n, stop_n, ctl_oe, par_out, par_oe;
  logic        cfg_enable, cfg_iswrite, detected_parity_error;
  logic [5:0]  cfg_offset;
  logic [3:0]  cfg_byte_en;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic        wr;
    logic [5:0]  off;
    logic [31:0] wv;
    logic [3:0]  be;
  } req_t;
  req_t exp_q[$];

  always #5 clk = ~clk;

  pci_cfg_target #(.TURNAROUND_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .frame_n(frame_n), .irdy_n(irdy_n), .idsel(idsel),
    .ad_in(ad_in), .cbe_n(cbe_n), .par_in(par_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .trdy_n(trdy_n), .devsel_n(devsel_n), .stop_n(stop_n),
    .ctl_oe(ctl_oe), .par_out(par_out), .par_oe(par_oe),
    .cfg_enable(cfg_enable), .cfg_iswrite(cfg_iswrite),
    .cfg_offset(cfg_offset), .cfg_write_val(cfg_write_val),
    .cfg_byte_en(cfg_byte_en), .cfg_read_val(cfg_read_val),
    .detected_parity_error(detected_parity_error)
  );

  // Register-block model: read data depends on the requested offset.
  function automatic logic [31:0] rd_model(input logic [5:0] off);
    return 32'h11E81234 ^ {26'd0, off};
  endfunction
  assign cfg_read_val = rd_model(cfg_offset);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic bus_idle();
    frame_n = 1'b1; irdy_n = 1'b1; idsel = 1'b0; ad_in = 32'd0; cbe_n = 4'hF; par_in = 1'b0;
  endtask

  // Scoreboard: every cfg_enable pulse must match the oldest expected request.
  always @(negedge clk) begin
    if (rst === 1'b1 && cfg_enable === 1'b1) begin
      compared++;
      assert (exp_q.size() != 0) else begin
        mismatched++;
        $error("FAIL sb_unexpected: got cfg_enable with off %0d want no request", cfg_offset);
      end
      if (exp_q.size() != 0) begin
        req_t e;
        e = exp_q.pop_front();
        compared++;
        assert ({cfg_iswrite, cfg_offset} === {e.wr, e.off}) else begin
          mismatched++;
          $error("FAIL sb_req: got wr %b off %0d want wr %b off %0d", cfg_iswrite, cfg_offset, e.wr, e.off);
        end
        if (e.wr) begin
          compared++;
          assert ({cfg_write_val, cfg_byte_en} === {e.wv, e.be}) else begin
            mismatched++;
            $error("FAIL sb_wdata: got %h/%b want %h/%b", cfg_write_val, cfg_byte_en, e.wv, e.be);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] rd;
    bus_idle();
    rst = 1'b0;
    tick(); tick();
    chk("rst_ctl", {trdy_n, devsel_n, stop_n, ad_oe, ctl_oe, par_oe}, 32'b111000);
    chk("rst_cfg", {cfg_enable, cfg_iswrite, cfg_offset, cfg_byte_en}, 32'd0);
    chk("rst_data", {ad_out ^ cfg_write_val}, 32'd0);
    chk("rst_par", {par_out, detected_parity_error}, 32'd0);
    rst = 1'b1;
    tick();

    // Single read, offset 0, FRAME# released in data phase.
    frame_n = 1'b0; idsel = 1'b1; ad_in = 32'h0; cbe_n = 4'b1010;
    exp_q.push_back('{wr: 1'b0, off: 6'd0, wv: 32'd0, be: 4'd0});
    tick();
    chk("rd_e0_ctl", {devsel_n, trdy_n, ctl_oe, cfg_enable}, 32'b0111);
    frame_n = 1'b1; irdy_n = 1'b0; idsel = 1'b0; cbe_n = 4'b0000;
    tick();
    chk("rd_e1_data", ad_out, 32'h11E81234);
    chk("rd_e1_ctl", {trdy_n, stop_n, ad_oe, cfg_enable}, 32'b0110);
    tick();
    chk("rd_done", {par_oe, ad_oe, trdy_n, devsel_n, stop_n, ctl_oe}, 32'b101111);
    chk("rd_par", par_out, ^{32'h11E81234, 4'b0000});
    bus_idle();
    tick();
    chk("rd_release", {ctl_oe, par_oe}, 32'b00);

    // Write, offset 1, data 6, byte enables 0011.
    tick();
    frame_n = 1'b0; idsel = 1'b1; ad_in = 32'h4; cbe_n = 4'b1011;
    tick();
    chk("wr_e0_ctl", {devsel_n, trdy_n, ctl_oe, cfg_enable}, 32'b0010);
    frame_n = 1'b1; irdy_n = 1'b0; idsel = 1'b0; ad_in = 32'h6; cbe_n = 4'b1100;
    exp_q.push_back('{wr: 1'b1, off: 6'd1, wv: 32'h6, be: 4'b0011});
    tick();
    chk("wr_pulse", {cfg_enable, cfg_iswrite, stop_n}, 32'b111);
    bus_idle();
    tick();
    chk("wr_turn", {cfg_enable, devsel_n, trdy_n, stop_n, ctl_oe}, 32'b01111);
    tick();
    chk("wr_release", ctl_oe, 32'd0);

    // Not claimed: idsel=0, memory read, nonzero function number.
    for (int i = 0; i < 3; i++) begin
      tick();
      frame_n = 1'b0;
      idsel   = (i != 0);
      cbe_n   = (i == 1) ? 4'b0110 : 4'b1010;
      ad_in   = (i == 2) ? 32'h100 : 32'h0;
      tick();
      frame_n = 1'b1; irdy_n = 1'b0; idsel = 1'b0;
      tick();
      chk($sformatf("nohit_%0d", i), {devsel_n, ctl_oe, trdy_n}, 32'b101);
      bus_idle();
    end

    // Burst read at offset 2: FRAME# held low through data.
    tick();
    frame_n = 1'b0; idsel = 1'b1; ad_in = 32'h8; cbe_n = 4'b1010;
    exp_q.push_back('{wr: 1'b0, off: 6'd2, wv: 32'd0, be: 4'd0});
    tick();
    irdy_n = 1'b0; idsel = 1'b0; cbe_n = 4'b0000;
    tick();
    chk("burst_ctl", {trdy_n, stop_n, devsel_n}, 32'b000);
    chk("burst_data", ad_out, rd_model(6'd2));
    tick();
    chk("burst_done", {trdy_n, stop_n, par_oe}, 32'b111);
    bus_idle();
    tick(); tick();

    // Read at offset 5 with IRDY# stalled for 5 cycles.
    frame_n = 1'b0; idsel = 1'b1; ad_in = 32'h14; cbe_n = 4'b1010;
    exp_q.push_back('{wr: 1'b0, off: 6'd5, wv: 32'd0, be: 4'd0});
    tick();
    frame_n = 1'b1; idsel = 1'b0; cbe_n = 4'b0101;
    tick();
    rd = rd_model(6'd5);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_%0d", i), {ad_out, 1'b0}, {rd, 1'b0});
      chk($sformatf("stall_ctl_%0d", i), {trdy_n, devsel_n, ad_oe, par_oe}, 32'b0010);
    end
    irdy_n = 1'b0;
    tick();
    chk("stall_done", {par_oe, trdy_n, par_out}, {30'd0, 1'b1, 1'b1, ^{rd, 4'b0101}});
    bus_idle();
    tick(); tick();

    // Address parity: odd-parity address phase with par_in low.
    frame_n = 1'b0; idsel = 1'b1; ad_in = 32'h4; cbe_n = 4'b1010;
    exp_q.push_back('{wr: 1'b0, off: 6'd1, wv: 32'd0, be: 4'd0});
    tick();
    frame_n = 1'b1; irdy_n = 1'b0; idsel = 1'b0; cbe_n = 4'b0000;
    par_in = 1'b0;  // correct value would be 1
    tick();
`ifdef PCI_CFG_TARGET_PARITY_CHECK_EN
    chk("perr_pulse", detected_parity_error, 32'd1);
    tick();
    chk("perr_once", detected_parity_error, 32'd0);
`else
    chk("perr_off", detected_parity_error, 32'd0);
    tick();
`endif
    bus_idle();
    tick(); tick();

    // Asynchronous reset in a stalled read data phase.
    frame_n = 1'b0; idsel = 1'b1; ad_in = 32'hC; cbe_n = 4'b1010;
    exp_q.push_back('{wr: 1'b0, off: 6'd3, wv: 32'd0, be: 4'd0});
    tick();
    frame_n = 1'b1; idsel = 1'b0; cbe_n = 4'b0000;
    tick(); tick();
    chk("pre_rst", {ad_oe, trdy_n}, 32'b10);
    #2 rst = 1'b0;
    #1;
    chk("async_rst", {ad_oe, ctl_oe, par_oe, cfg_enable, trdy_n, devsel_n, stop_n}, 32'b0000111);
    bus_idle();
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    chk("post_rst", {devsel_n, ctl_oe}, 32'b10);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
